// File: rtl/pipe_hazard_ctrl.sv
// RAW hazard stall (zero latency) plus host-access FSM RUN->DRAIN(3)->HOST; host_grant registered, host holds until it drops host_req.
// Optional saturating stall counter on stall_cnt when PIPE_HAZARD_STATS_EN is defined; otherwise stall_cnt is tied to zero.
module pipe_hazard_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        dec_valid,
  input  logic        dec_use_rs1,
  input  logic        dec_use_rs2,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        idex_wregen,
  input  logic        exmem_wregen,
  input  logic        memwb_wregen,
  input  logic [4:0]  idex_wreg,
  input  logic [4:0]  exmem_wreg,
  input  logic [4:0]  memwb_wreg,
  input  logic        host_req,
  output logic        stall_pc,
  output logic        idex_bubble,
  output logic        host_grant,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOST  = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] drain_cnt, drain_nxt;
  logic       rs1_hit, rs2_hit, raw, stall;

  // Register 0 is hardwired, so it can never be a hazard source.
  assign rs1_hit = dec_use_rs1 && (dec_rs1 != 5'd0) &&
                   ((idex_wregen  && (idex_wreg  == dec_rs1)) ||
                    (exmem_wregen && (exmem_wreg == dec_rs1)) ||
                    (memwb_wregen && (memwb_wreg == dec_rs1)));
  assign rs2_hit = dec_use_rs2 && (dec_rs2 != 5'd0) &&
                   ((idex_wregen  && (idex_wreg  == dec_rs2)) ||
                    (exmem_wregen && (exmem_wreg == dec_rs2)) ||
                    (memwb_wregen && (memwb_wreg == dec_rs2)));
  assign raw = dec_valid && (rs1_hit || rs2_hit);

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    stall     = raw;
    case (state)
      RUN: begin
        if (host_req) begin
          state_nxt = DRAIN;
          drain_nxt = 2'd3;
          stall     = 1'b1;
        end
      end
      DRAIN: begin
        stall = 1'b1;
        if (drain_cnt <= 2'd1) begin
          state_nxt = HOST;
          drain_nxt = 2'd0;
        end else begin
          drain_nxt = drain_cnt - 2'd1;
        end
      end
      HOST: begin
        stall = 1'b1;
        if (!host_req) state_nxt = RUN;
      end
      default: begin
        state_nxt = RUN;
        drain_nxt = 2'd0;
      end
    endcase
    // During reset the pipeline sees only the plain hazard rule.
    if (RST) stall = raw;
  end

  assign stall_pc    = stall;
  assign idex_bubble = stall;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= RUN;
      drain_cnt  <= 2'd0;
      host_grant <= 1'b0;
    end else begin
      state      <= state_nxt;
      drain_cnt  <= drain_nxt;
      host_grant <= (state_nxt == HOST);
    end
  end

`ifdef PIPE_HAZARD_STATS_EN
  logic [31:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q <= 32'd0;
    end else if (stall && (cnt_q != 32'hFFFF_FFFF)) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and randomized bench for pipe_hazard_ctrl, checked against a session-age model.
module tb_pipe_hazard_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        dec_valid, dec_use_rs1, dec_use_rs2;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        idex_wregen, exmem_wregen, memwb_wregen;
  logic [4:0]  idex_wreg, exmem_wreg, memwb_wreg;
  logic        host_req;
  logic        stall_pc, idex_bubble, host_grant;
  logic [31:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: a host session starts in the cycle host_req is seen in run mode (age 0);
  // ages 0..3 are bubbles only, age >= 4 is granted until host_req is seen low.
  bit      m_sess = 1'b0;
  int      m_age  = 0;
  longint  m_cnt  = 0;

  pipe_hazard_ctrl dut (
    .CLK(CLK), .RST(RST),
    .dec_valid(dec_valid), .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .idex_wregen(idex_wregen), .exmem_wregen(exmem_wregen), .memwb_wregen(memwb_wregen),
    .idex_wreg(idex_wreg), .exmem_wreg(exmem_wreg), .memwb_wreg(memwb_wreg),
    .host_req(host_req),
    .stall_pc(stall_pc), .idex_bubble(idex_bubble), .host_grant(host_grant),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_raw();
    bit [4:0] wr [3];
    bit       en [3];
    bit [4:0] rs;
    bit       use_rs;
    wr[0] = idex_wreg;   en[0] = idex_wregen;
    wr[1] = exmem_wreg;  en[1] = exmem_wregen;
    wr[2] = memwb_wreg;  en[2] = memwb_wregen;
    for (int s = 0; s < 2; s++) begin
      rs     = (s == 0) ? dec_rs1 : dec_rs2;
      use_rs = (s == 0) ? dec_use_rs1 : dec_use_rs2;
      if (use_rs && rs != 5'd0)
        for (int k = 0; k < 3; k++)
          if (en[k] && wr[k] == rs) return dec_valid;
    end
    return 1'b0;
  endfunction

  // Checks one cycle (inputs already applied at the preceding negedge), then
  // advances the model across the rising edge. exp_* of -1 means no extra constant check.
  task automatic cycle(input string tag, input int exp_stall = -1, input int exp_grant = -1);
    bit stall_e, grant_e;
    #2;
    if (RST)         stall_e = model_raw();
    else if (m_sess) stall_e = 1'b1;
    else             stall_e = host_req ? 1'b1 : model_raw();
    grant_e = m_sess && (m_age >= 4);
    chk({tag, "_stall_pc"},    stall_pc,    32'(stall_e));
    chk({tag, "_idex_bubble"}, idex_bubble, 32'(stall_e));
    chk({tag, "_host_grant"},  host_grant,  32'(grant_e));
`ifdef PIPE_HAZARD_STATS_EN
    chk({tag, "_stall_cnt"},   stall_cnt,   32'(m_cnt));
`else
    chk({tag, "_stall_cnt"},   stall_cnt,   32'd0);
`endif
    if (exp_stall >= 0) chk({tag, "_const_stall"}, stall_pc,   32'(exp_stall));
    if (exp_grant >= 0) chk({tag, "_const_grant"}, host_grant, 32'(exp_grant));
    if (RST) begin
      m_sess = 1'b0;
      m_cnt  = 0;
    end else begin
      if (stall_e && m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (!m_sess) begin
        if (host_req) begin m_sess = 1'b1; m_age = 1; end
      end else if (m_age >= 4 && !host_req) begin
        m_sess = 1'b0;
      end else begin
        m_age++;
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    dec_valid = 0; dec_use_rs1 = 0; dec_use_rs2 = 0; dec_rs1 = 0; dec_rs2 = 0;
    idex_wregen = 0; exmem_wregen = 0; memwb_wregen = 0;
    idex_wreg = 0; exmem_wreg = 0; memwb_wreg = 0; host_req = 0;
  endtask

  task automatic set_hazard();
    idle_inputs();
    dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd5; idex_wreg = 5'd5; idex_wregen = 1;
  endtask

  initial begin
    idle_inputs();
    RST = 1'b1;
    @(negedge CLK);
    cycle("reset", 0, 0);
    RST = 1'b0;

    // Same-cycle hazard on idex, then cleared by removing the match.
    set_hazard();
    cycle("rs1_idex_hit", 1);
    dec_rs1 = 5'd6;
    cycle("rs1_idex_clear", 0);

    // Register 0 never stalls even with every writer targeting it.
    idle_inputs();
    dec_valid = 1; dec_use_rs2 = 1; dec_rs2 = 5'd0;
    idex_wregen = 1; exmem_wregen = 1; memwb_wregen = 1;
    cycle("rs2_zero", 0);

    // memwb match only counts when its write enable is set.
    idle_inputs();
    dec_valid = 1; dec_use_rs1 = 1; dec_rs1 = 5'd7; memwb_wreg = 5'd7;
    cycle("memwb_noen", 0);
    memwb_wregen = 1;
    cycle("memwb_en", 1);

    // Host session: request at t, grant from t+4, release at t+10, grant low at t+11.
    idle_inputs();
    host_req = 1;
    for (int i = 0; i < 4; i++) cycle("host_drain", 1, 0);
    for (int i = 4; i < 10; i++) cycle("host_held", 1, 1);
    host_req = 0;
    cycle("host_release", 1, 1);
    cycle("host_after", 0, 0);

    // Host request with a simultaneous hazard, then reset during HOST.
    set_hazard();
    host_req = 1;
    cycle("host_and_raw", 1, 0);
    idle_inputs();
    cycle("drain_drop_req", 1, 0);
    host_req = 1;
    cycle("drain2", 1, 0);
    cycle("drain3", 1, 0);
    cycle("host_pre_rst", 1, 1);
    RST = 1;
    cycle("rst_in_host", 0, 1);
    RST = 0; host_req = 0;
    cycle("post_rst", 0, 0);

    // Statistics: 3 hazard cycles + entry + 3 drain + 5 grant cycles.
    RST = 1;
    cycle("stats_reset", 0);
    RST = 0;
    set_hazard();
    for (int i = 0; i < 3; i++) cycle("stats_hazard", 1);
    idle_inputs();
    cycle("stats_gap", 0);
    host_req = 1;
    for (int i = 0; i < 8; i++) cycle("stats_host", 1);
    host_req = 0;
    cycle("stats_release", 1, 1);
    #2;
`ifdef PIPE_HAZARD_STATS_EN
    chk("stats_total", stall_cnt, 32'd12);
`else
    chk("stats_total", stall_cnt, 32'd0);
`endif
    cycle("stats_idle", 0, 0);

    // Randomized traffic with a narrow register range so matches are frequent.
    for (int n = 0; n < 3000; n++) begin
      dec_valid    = ($urandom_range(0, 3) != 0);
      dec_use_rs1  = $urandom_range(0, 1);
      dec_use_rs2  = $urandom_range(0, 1);
      dec_rs1      = 5'($urandom_range(0, 4));
      dec_rs2      = 5'($urandom_range(0, 4));
      idex_wregen  = $urandom_range(0, 1);
      exmem_wregen = $urandom_range(0, 1);
      memwb_wregen = $urandom_range(0, 1);
      idex_wreg    = 5'($urandom_range(0, 4));
      exmem_wreg   = 5'($urandom_range(0, 4));
      memwb_wreg   = 5'($urandom_range(0, 4));
      if ($urandom_range(0, 9) == 0) host_req = ~host_req;
      RST = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1, synchronous active-high reset sampled on the rising edge of CLK.
REQ-003 SHALL have ports dec_valid, dec_use_rs1 and dec_use_rs2, inputs, 1 each: decode-stage instruction valid, and whether it reads source 1 / source 2.
REQ-004 SHALL have ports dec_rs1 and dec_rs2, inputs, 5 each: decode-stage source register indices.
REQ-005 SHALL have ports idex_wregen, exmem_wregen and memwb_wregen, inputs, 1 each: register-write enable held in each in-flight pipeline register.
REQ-006 SHALL have ports idex_wreg, exmem_wreg and memwb_wreg, inputs, 5 each: destination register index held in each in-flight pipeline register.
REQ-007 SHALL have port host_req, input, 1: external host requests exclusive register-file/data-memory access.
REQ-008 SHALL have port stall_pc, output, 1: hold PC and the IF/ID register.
REQ-009 SHALL have port idex_bubble, output, 1: force WRegEn_in and WMemEn_in of the ID/EX register to 0.
REQ-010 SHALL have port host_grant, output, 1, registered: host owns the register file and data memory.
REQ-011 SHALL have port stall_cnt, output, 32: stall statistics counter (see Configuration).

Function
REQ-012 SHALL compute raw = dec_valid AND (match(rs1) OR match(rs2)), where match(rsN) = dec_use_rsN AND rsN != 0 AND rsN equals any X_wreg with X_wregen = 1 (X = idex, exmem, memwb).
REQ-013 SHALL never flag a hazard on register 0, regardless of the wregen inputs.
REQ-014 SHALL implement FSM states RUN, DRAIN and HOST, encoded in 2 bits; the unused encoding SHALL go to RUN on the next cycle.
REQ-015 SHALL, in RUN, drive stall_pc = idex_bubble = raw combinationally, in the same cycle (zero latency).
REQ-016 SHALL, in RUN with host_req = 1, go to DRAIN, load drain_cnt = 3, and drive stall_pc = idex_bubble = 1 in that cycle; host_req takes priority over raw.
REQ-017 SHALL, in DRAIN, drive stall_pc = idex_bubble = 1 and decrement drain_cnt each cycle.
REQ-018 SHALL, in DRAIN, go to HOST when drain_cnt = 1, so that DRAIN lasts exactly 3 cycles.
REQ-019 SHALL, in DRAIN, ignore a deassertion of host_req; the drain always completes.
REQ-020 SHALL, in HOST, drive host_grant = 1 (registered, asserted on the first HOST cycle) and stall_pc = idex_bubble = 1.
REQ-021 SHALL, in HOST with host_req = 0, go to RUN; host_grant SHALL be 0 on the next cycle, and RUN outputs apply from then on.
REQ-022 SHALL keep host_req = 1 held continuously in HOST, with no timeout.
REQ-023 SHALL keep drain_cnt 2 bits wide; it SHALL not wrap outside DRAIN.

Reset
REQ-024 SHALL, on RST = 1 at a rising edge, set state = RUN, drain_cnt = 0, host_grant = 0 and stall_cnt = 0.
REQ-025 SHALL treat reset mid-DRAIN or mid-HOST the same way: grant drops on the next cycle and the pending drain is abandoned.
REQ-026 SHALL give RST precedence over all other inputs.
REQ-027 SHALL, while RST = 1 and after reset, drive the combinational outputs per the RUN rule.

Configuration
REQ-028 SHALL use macro PIPE_HAZARD_STATS_EN.
REQ-029 SHALL, when PIPE_HAZARD_STATS_EN is defined, increment stall_cnt by 1 in every non-reset cycle with stall_pc = 1, saturating at 32'hFFFF_FFFF.
REQ-030 SHALL, when PIPE_HAZARD_STATS_EN is undefined, tie stall_cnt to 32'd0 and infer no counter flops.

Verification
REQ-031 SHALL cover: dec_rs1 = 5, dec_use_rs1 = 1, idex_wreg = 5, idex_wregen = 1 -> stall_pc = idex_bubble = 1 in the same cycle; match removed -> both 0.
REQ-032 SHALL cover: dec_rs2 = 0 with all wreg = 0 and wregen = 1 -> no stall.
REQ-033 SHALL cover: dec_rs1 = 7 matching only memwb_wreg = 7 with memwb_wregen = 0 -> no stall; with memwb_wregen = 1 -> stall.
REQ-034 SHALL cover: host_req rises at cycle t -> bubbles in cycles t..t+3, host_grant = 1 from t+4; host_req falls at t+10 -> host_grant = 0 at t+11.
REQ-035 SHALL cover: host_req with raw = 1 simultaneously -> DRAIN entered; RST pulsed during HOST -> host_grant = 0 and state RUN next cycle.
REQ-036 SHALL cover, with PIPE_HAZARD_STATS_EN defined: 3 hazard cycles plus one host session of 5 grant cycles -> stall_cnt = 3 + 4 + 5 = 12, counting the entry cycle and 3 DRAIN cycles.
